// File: rtl/vx_writeback_arb_pkg.sv
// Shared types and helpers for the writeback arbiter.
//   sel_width() : source-index width, never less than one bit
//   wb_tag_t    : packet framing bits stored alongside each payload beat
//   lock_state_e: packet-atomicity lock FSM states
package vx_writeback_arb_pkg;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic sop;
    logic eop;
  } wb_tag_t;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/vx_writeback_arb_if.sv
// Writeback arbiter bus bundle.
//   in_*      : NUM_INPUTS source streams (valid/ready, flat payload, sop/eop)
//   out_*     : merged commit-side stream plus the source index of each beat
//   proto_err : sticky framing-violation flag
// master = the surrounding system (sources + commit), slave = the arbiter.
interface vx_writeback_arb_if
  import vx_writeback_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATAW      = 128,
  parameter int unsigned SEL_W      = sel_width(NUM_INPUTS)
) ();

  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic [NUM_INPUTS*DATAW-1:0] in_data;
  logic [NUM_INPUTS-1:0]       in_sop;
  logic [NUM_INPUTS-1:0]       in_eop;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATAW-1:0]            out_data;
  logic                        out_sop;
  logic                        out_eop;
  logic [SEL_W-1:0]            out_sel;
  logic                        proto_err;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_sel, proto_err
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_sel, proto_err
  );

endinterface

// File: rtl/vx_writeback_arb_fifo.sv
// Per-source synchronous FIFO, Depth x Width, no read bypass.
//   clk, reset_n : clock, async active-low reset (pointers/count only)
//   push, wdata  : write strobe (ignored when full) and word
//   pop, rdata   : read strobe (ignored when empty) and head word
//   full, empty  : occupancy flags, purely from registered state
module vx_writeback_arb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 130
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/vx_writeback_arb.sv
// N-input writeback arbiter: per-source FIFOs, packet-atomic round-robin,
// registered output with valid/ready backpressure.
//   clk, reset_n : clock, async active-low reset
//   wb (slave)   : in_* source streams, out_* merged stream, proto_err
module vx_writeback_arb
  import vx_writeback_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATAW      = 128,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned SEL_W      = sel_width(NUM_INPUTS)
) (
  input logic               clk,
  input logic               reset_n,
  vx_writeback_arb_if.slave wb
);

  localparam int unsigned WordW = DATAW + 2;

  logic [NUM_INPUTS-1:0] push, pop, full, empty;
  logic [WordW-1:0]      head [NUM_INPUTS];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_fifo
    assign push[g] = wb.in_valid[g] & ~full[g];
    vx_writeback_arb_fifo #(
      .Depth (BUF_DEPTH),
      .Width (WordW)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[g]),
      .wdata   ({wb.in_data[g*DATAW +: DATAW], wb.in_sop[g], wb.in_eop[g]}),
      .pop     (pop[g]),
      .rdata   (head[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  assign wb.in_ready = ~full;

  lock_state_e      lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d, rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [NUM_INPUTS-1:0] in_pkt_q, in_pkt_d;
  logic             err_q, err_d;

  logic             grant_valid, load, do_pop;
  logic [SEL_W-1:0] grant_idx;
  logic [WordW-1:0] win_word;
  wb_tag_t          win_tag;

  always_comb begin : p_arb
    int unsigned c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (lock_q == StLocked) begin
      // Mid-packet: only the owning source may proceed.
      grant_valid = ~empty[lock_idx_q];
      grant_idx   = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        c = 32'(rr_ptr_q) + k;
        if (c >= NUM_INPUTS) c = c - NUM_INPUTS;
        if (!grant_valid && !empty[SEL_W'(c)]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(c);
        end
      end
    end
  end

  assign win_word = head[grant_idx];
  assign win_tag  = win_word[1:0];
  assign load     = ~out_valid_q | wb.out_ready;
  assign do_pop   = load & grant_valid;

  always_comb begin
    pop            = '0;
    pop[grant_idx] = do_pop;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_sel_d   = out_sel_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = win_word[WordW-1:2];
        out_sop_d  = win_tag.sop;
        out_eop_d  = win_tag.eop;
        out_sel_d  = grant_idx;
      end
    end
    if (do_pop) begin
      if (win_tag.eop) begin
        lock_d   = StUnlocked;
        rr_ptr_d = (grant_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end else if (win_tag.sop) begin
        lock_d     = StLocked;
        lock_idx_d = grant_idx;
      end
    end
  end

  // Framing check on accepted input beats: a violation is exactly the case
  // where sop agrees with in-packet (sop inside a packet, or continuation outside).
  always_comb begin
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) begin
        if (wb.in_sop[i] == in_pkt_q[i]) err_d = 1'b1;
        if (wb.in_eop[i])      in_pkt_d[i] = 1'b0;
        else if (wb.in_sop[i]) in_pkt_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= StUnlocked;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_sel_q   <= '0;
      in_pkt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_sel_q   <= out_sel_d;
      in_pkt_q    <= in_pkt_d;
      err_q       <= err_d;
    end
  end

  assign wb.out_valid = out_valid_q;
  assign wb.out_data  = out_data_q;
  assign wb.out_sop   = out_sop_q;
  assign wb.out_eop   = out_eop_q;
  assign wb.out_sel   = out_sel_q;
  assign wb.proto_err = err_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed bench for vx_writeback_arb (4 sources, 128-bit payload, depth 2).
module tb_vx_writeback_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 128;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  vx_writeback_arb_if #(.NUM_INPUTS(N), .DATAW(DW)) wb ();

  vx_writeback_arb #(
    .NUM_INPUTS (N),
    .DATAW      (DW),
    .BUF_DEPTH  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic s, input logic e,
                       input logic [DW-1:0] d);
    wb.in_valid[i]          = v;
    wb.in_sop[i]            = s;
    wb.in_eop[i]            = e;
    wb.in_data[i*DW +: DW]  = d;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [1:0] sel, input logic [DW-1:0] d,
                            input logic s, input logic e);
    check({tag, "_valid"}, DW'(wb.out_valid), DW'(1));
    check({tag, "_sel"}, DW'(wb.out_sel), DW'(sel));
    check({tag, "_data"}, wb.out_data, d);
    check({tag, "_sop"}, DW'(wb.out_sop), DW'(s));
    check({tag, "_eop"}, DW'(wb.out_eop), DW'(e));
  endtask

  initial begin
    reset_n      = 1'b0;
    wb.out_ready = 1'b1;
    wb.in_valid  = '1;
    wb.in_sop    = '1;
    wb.in_eop    = '1;
    wb.in_data   = {N*DW/32{32'hdeadbeef}};

    // 1. reset with traffic offered, then simultaneous singles from all sources
    tick();
    tick();
    check("rst_valid", DW'(wb.out_valid), DW'(0));
    check("rst_data", wb.out_data, DW'(0));
    check("rst_sop", DW'(wb.out_sop), DW'(0));
    check("rst_eop", DW'(wb.out_eop), DW'(0));
    check("rst_sel", DW'(wb.out_sel), DW'(0));
    check("rst_err", DW'(wb.proto_err), DW'(0));
    check("rst_ready", DW'(wb.in_ready), DW'(4'hF));
    wb.in_valid = '0;
    reset_n     = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 1'b1, DW'(8'hA0 + i));
    tick();
    wb.in_valid = '0;
    check("t1_lat", DW'(wb.out_valid), DW'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_beat($sformatf("t1_b%0d", i), 2'(i), DW'(8'hA0 + i), 1'b1, 1'b1);
    end
    tick();
    check("t1_idle", DW'(wb.out_valid), DW'(0));

    // 2. packet atomicity: 3-beat packet from source 1, source 0 keeps offering
    drive(0, 1'b1, 1'b1, 1'b1, DW'(8'h01));
    drive(1, 1'b1, 1'b1, 1'b0, DW'(8'h11));
    drive(2, 1'b1, 1'b1, 1'b1, DW'(8'h21));
    drive(3, 1'b1, 1'b1, 1'b1, DW'(8'h31));
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, DW'(8'h12));
    drive(2, 1'b0, 1'b0, 1'b0, '0);
    drive(3, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t2_b0", 2'd0, DW'(8'h01), 1'b1, 1'b1);
    check("t2_rdy1", DW'(wb.in_ready[1]), DW'(0));
    drive(1, 1'b1, 1'b0, 1'b1, DW'(8'h13));
    tick();
    check_beat("t2_b1", 2'd1, DW'(8'h11), 1'b1, 1'b0);
    tick();
    check_beat("t2_b2", 2'd1, DW'(8'h12), 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t2_b3", 2'd1, DW'(8'h13), 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t2_b4", 2'd2, DW'(8'h21), 1'b1, 1'b1);
    tick();
    check_beat("t2_b5", 2'd3, DW'(8'h31), 1'b1, 1'b1);
    tick();
    check_beat("t2_b6", 2'd0, DW'(8'h01), 1'b1, 1'b1);
    tick();
    check_beat("t2_b7", 2'd0, DW'(8'h01), 1'b1, 1'b1);
    tick();
    check("t2_idle", DW'(wb.out_valid), DW'(0));

    // 3. backpressure: out_ready low for five edges while source 2 streams
    wb.out_ready = 1'b0;
    drive(2, 1'b1, 1'b1, 1'b1, DW'(8'h41));
    tick();
    check("t3_lat", DW'(wb.out_valid), DW'(0));
    drive(2, 1'b1, 1'b1, 1'b1, DW'(8'h42));
    tick();
    check_beat("t3_h0", 2'd2, DW'(8'h41), 1'b1, 1'b1);
    drive(2, 1'b1, 1'b1, 1'b1, DW'(8'h43));
    tick();
    check_beat("t3_h1", 2'd2, DW'(8'h41), 1'b1, 1'b1);
    check("t3_rdy_a", DW'(wb.in_ready[2]), DW'(0));
    drive(2, 1'b1, 1'b1, 1'b1, DW'(8'h44));
    tick();
    check("t3_h2", wb.out_data, DW'(8'h41));
    check("t3_rdy_b", DW'(wb.in_ready[2]), DW'(0));
    tick();
    check_beat("t3_h3", 2'd2, DW'(8'h41), 1'b1, 1'b1);
    wb.out_ready = 1'b1;
    tick();
    check_beat("t3_r0", 2'd2, DW'(8'h42), 1'b1, 1'b1);
    tick();
    check_beat("t3_r1", 2'd2, DW'(8'h43), 1'b1, 1'b1);
    drive(2, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t3_r2", 2'd2, DW'(8'h44), 1'b1, 1'b1);
    tick();
    check("t3_idle", DW'(wb.out_valid), DW'(0));

    // 4. pointer wrap: rr_ptr is 3, sources 3 and 0 offer together
    drive(3, 1'b1, 1'b1, 1'b1, DW'(8'h51));
    drive(0, 1'b1, 1'b1, 1'b1, DW'(8'h61));
    tick();
    drive(3, 1'b0, 1'b0, 1'b0, '0);
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t4_b0", 2'd3, DW'(8'h51), 1'b1, 1'b1);
    tick();
    check_beat("t4_b1", 2'd0, DW'(8'h61), 1'b1, 1'b1);
    tick();
    check("t4_idle", DW'(wb.out_valid), DW'(0));

    // 5. protocol error: sop, sop, eop on source 0
    drive(0, 1'b1, 1'b1, 1'b0, DW'(8'h71));
    tick();
    check("t5_err0", DW'(wb.proto_err), DW'(0));
    drive(0, 1'b1, 1'b1, 1'b0, DW'(8'h72));
    tick();
    check("t5_err1", DW'(wb.proto_err), DW'(1));
    check_beat("t5_b0", 2'd0, DW'(8'h71), 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, DW'(8'h73));
    tick();
    check_beat("t5_b1", 2'd0, DW'(8'h72), 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t5_b2", 2'd0, DW'(8'h73), 1'b0, 1'b1);
    tick();
    check("t5_err2", DW'(wb.proto_err), DW'(1));
    check("t5_idle", DW'(wb.out_valid), DW'(0));

    // 6. async reset while source 1 holds the lock
    drive(1, 1'b1, 1'b1, 1'b0, DW'(8'h81));
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, DW'(8'h82));
    tick();
    check_beat("t6_b0", 2'd1, DW'(8'h81), 1'b1, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", DW'(wb.out_valid), DW'(0));
    check("t6_rst_data", wb.out_data, DW'(0));
    check("t6_rst_sel", DW'(wb.out_sel), DW'(0));
    check("t6_rst_err", DW'(wb.proto_err), DW'(0));
    tick();
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b1, DW'(8'h91));
    drive(1, 1'b1, 1'b1, 1'b1, DW'(8'hB1));
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_beat("t6_b1", 2'd0, DW'(8'h91), 1'b1, 1'b1);
    tick();
    check_beat("t6_b2", 2'd1, DW'(8'hB1), 1'b1, 1'b1);
    tick();
    check("t6_idle", DW'(wb.out_valid), DW'(0));
    check("t6_err", DW'(wb.proto_err), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
